// File: rtl/user_ip_apb_pkg.sv
// Shared types and defaults for the memory-to-APB4 bridge.
package user_ip_apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } bridge_state_e;

    localparam logic [31:0] ErrRdataDefault = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle; the bridge connects through the master modport.
interface apb4_if;

    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/user_ip_apb_bridge.sv
// Bridges a valid/ready memory request port onto an APB4 master with an
// optional ACCESS-phase timeout that returns an error response.
module user_ip_apb_bridge
    import user_ip_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = ErrRdataDefault
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o,
    output logic [7:0]  tmo_cnt_o,
    apb4_if.master      apb
);

    // A zero-width counter is illegal, so a disabled timeout keeps one bit.
    localparam int unsigned    TmoW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    bridge_state_e   state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TmoW-1:0] timer_q, timer_d;
    logic [7:0]      tmo_cnt_q, tmo_cnt_d;

    logic is_write;
    assign is_write = |wstrb_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timer_d   = timer_q;
        tmo_cnt_d = tmo_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (mem_valid_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    wstrb_d = mem_wstrb_i;
                    timer_d = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (apb.pready) begin
                    rdata_d = is_write ? 32'h0 : apb.prdata;
                    err_d   = apb.pslverr;
                    state_d = StResp;
                end else if ((TIMEOUT_CYC != 0) && (timer_q == TmoLast)) begin
                    // Timeout reports ERR_RDATA for reads and writes alike.
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                    if (tmo_cnt_q != 8'hFF) begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                    state_d = StResp;
                end else if (TIMEOUT_CYC != 0) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign apb.psel    = (state_q == StSetup) || (state_q == StAccess);
    assign apb.penable = (state_q == StAccess);
    assign apb.paddr   = addr_q;
    assign apb.pwdata  = wdata_q;
    assign apb.pstrb   = wstrb_q;
    assign apb.pwrite  = is_write;
    assign apb.pprot   = 3'b000;

    assign mem_ready_o = (state_q == StResp);
    assign mem_rdata_o = rdata_q;
    assign mem_err_o   = err_q;
    assign tmo_cnt_o   = tmo_cnt_q;

endmodule

// File: tb/tb_user_ip_apb_bridge.sv
// Self-checking bench: directed vector table, randomized transfers against a
// behavioural model, timeout saturation, mid-transfer reset, disabled timeout.
module tb_user_ip_apb_bridge;

    localparam int unsigned Tmo     = 4;
    localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        ready, err, ready_z, err_z;
    logic [31:0] rdata, rdata_z;
    logic [7:0]  tmo_cnt, tmo_cnt_z;
    logic        s_pready, s_pslverr;
    logic [31:0] s_prdata;

    apb4_if apb ();
    apb4_if apb_z ();

    assign apb.pready    = s_pready;
    assign apb.prdata    = s_prdata;
    assign apb.pslverr   = s_pslverr;
    assign apb_z.pready  = s_pready;
    assign apb_z.prdata  = s_prdata;
    assign apb_z.pslverr = s_pslverr;

    always #5 clk = ~clk;

    user_ip_apb_bridge #(.TIMEOUT_CYC(Tmo)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_valid_i (mem_valid),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_ready_o (ready),
        .mem_rdata_o (rdata),
        .mem_err_o   (err),
        .tmo_cnt_o   (tmo_cnt),
        .apb         (apb)
    );

    user_ip_apb_bridge #(.TIMEOUT_CYC(0)) dut_z (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_valid_i (mem_valid),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_ready_o (ready_z),
        .mem_rdata_o (rdata_z),
        .mem_err_o   (err_z),
        .tmo_cnt_o   (tmo_cnt_z),
        .apb         (apb_z)
    );

    int errors = 0;
    int checks = 0;
    int model_tmo = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          stall;
        logic        slverr;
        logic [31:0] prdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        bit          to;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a slave stalling for `stall` ACCESS cycles either
    // answers after 3+stall cycles, or is cut off after Tmo stalled cycles.
    task automatic model(input logic [3:0] wstrb, input int stall, input logic slverr,
                         input logic [31:0] prdata, output int lat, output logic [31:0] rd,
                         output logic er, output bit to);
        if (stall >= int'(Tmo)) begin
            lat = int'(Tmo) + 2;
            rd  = ErrData;
            er  = 1'b1;
            to  = 1'b1;
        end else begin
            lat = 3 + stall;
            rd  = (wstrb == 4'b0000) ? prdata : 32'h0;
            er  = slverr;
            to  = 1'b0;
        end
    endtask

    task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int stall, input logic slverr,
                        input logic [31:0] prdata, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit exp_to,
                        input bit chk_rdata);
        int   cyc;
        int   acc;
        logic unstable;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        s_pready  = 1'b0;
        s_pslverr = 1'b0;
        tick;
        cyc = 1;
        check({tag, " setup psel"}, apb.psel, 1);
        check({tag, " setup penable"}, apb.penable, 0);
        check({tag, " paddr"}, apb.paddr, addr);
        check({tag, " pwrite"}, apb.pwrite, (wstrb != 4'b0000));
        check({tag, " pstrb"}, apb.pstrb, wstrb);
        check({tag, " pwdata"}, apb.pwdata, wdata);
        check({tag, " pprot"}, apb.pprot, 0);
        // Request fields change while valid stays high; the bridge must ignore them.
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
        acc = 0;
        unstable = 1'b0;
        while (!ready && cyc < 40) begin
            if (apb.psel && apb.penable) begin
                if (apb.paddr !== addr || apb.pwdata !== wdata || apb.pstrb !== wstrb)
                    unstable = 1'b1;
                s_pready  = (acc >= stall);
                s_pslverr = (acc >= stall) ? slverr : 1'b0;
                s_prdata  = (acc >= stall) ? prdata : $urandom;
                acc++;
            end
            tick;
            cyc++;
        end
        if (exp_to) model_tmo = (model_tmo < 255) ? model_tmo + 1 : 255;
        check({tag, " access stable"}, unstable, 0);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " ready"}, ready, 1);
        if (chk_rdata) check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " err"}, err, exp_err);
        check({tag, " tmo_cnt"}, tmo_cnt, model_tmo);
        check({tag, " resp psel"}, apb.psel, 0);
        mem_valid = 1'b0;
        s_pready  = 1'b0;
        s_pslverr = 1'b0;
        tick;
        check({tag, " ready one cycle"}, ready, 0);
        check({tag, " idle psel"}, apb.psel, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        bit          to;
        logic        saw;

        vecs[0] = '{32'h10, 32'h0, 4'b0000, 0, 1'b0, 32'h0000_00FF, 3, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[1] = '{32'h04, 32'hA5A5_A5A5, 4'b0011, 0, 1'b0, 32'h1234_5678, 3, 32'h0, 1'b0, 1'b0};
        vecs[2] = '{32'h20, 32'h0, 4'b0000, 3, 1'b1, 32'h0000_0011, 6, 32'h0000_0011, 1'b1, 1'b0};
        vecs[3] = '{32'h30, 32'h0, 4'b0000, 10, 1'b0, 32'h0000_0022, 6, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[4] = '{32'h40, 32'h0102_0304, 4'b1111, 2, 1'b0, 32'h99, 5, 32'h0, 1'b0, 1'b0};
        vecs[5] = '{32'h44, 32'hFFFF_0000, 4'b1000, 1, 1'b1, 32'h77, 4, 32'h0, 1'b1, 1'b0};
        vecs[6] = '{32'h48, 32'h0, 4'b0000, 3, 1'b0, 32'hCAFE_F00D, 6, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[7] = '{32'h4C, 32'h0, 4'b0000, 4, 1'b0, 32'h33, 6, 32'hDEAD_BEEF, 1'b1, 1'b1};

        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        s_pready  = 1'b0;
        s_pslverr = 1'b0;
        s_prdata  = '0;
        repeat (3) tick;
        check("reset psel", apb.psel, 0);
        check("reset penable", apb.penable, 0);
        check("reset pwrite", apb.pwrite, 0);
        check("reset paddr", apb.paddr, 0);
        check("reset pwdata", apb.pwdata, 0);
        check("reset pstrb", apb.pstrb, 0);
        check("reset ready", ready, 0);
        check("reset err", err, 0);
        check("reset rdata", rdata, 0);
        check("reset tmo_cnt", tmo_cnt, 0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                 vecs[i].stall, vecs[i].slverr, vecs[i].prdata, vecs[i].lat, vecs[i].rdata,
                 vecs[i].err, vecs[i].to, 1'b1);
        end

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, w, p;
            logic [3:0]  s;
            int          st;
            logic        se;
            a  = $urandom;
            w  = $urandom;
            p  = $urandom;
            s  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            st = $urandom_range(0, 6);
            se = 1'($urandom_range(0, 1));
            model(s, st, se, p, lat, rd, er, to);
            xfer($sformatf("rnd%0d", i), a, w, s, st, se, p, lat, rd, er, to,
                 !(to && s != 4'b0000));
        end

        for (int i = 0; i < 300; i++) begin
            model(4'b0000, 10, 1'b0, 32'h0, lat, rd, er, to);
            xfer("sat", 32'h100, 32'h0, 4'b0000, 10, 1'b0, 32'h0, lat, rd, er, to, 1'b1);
        end
        check("tmo saturate", tmo_cnt, 255);

        // Reset while the slave is stalling in ACCESS.
        mem_valid = 1'b1;
        mem_addr  = 32'h200;
        mem_wstrb = 4'b0000;
        s_pready  = 1'b0;
        repeat (3) tick;
        check("midrst in access", apb.penable, 1);
        rst       = 1'b1;
        mem_valid = 1'b0;
        tick;
        check("midrst psel", apb.psel, 0);
        check("midrst penable", apb.penable, 0);
        check("midrst ready", ready, 0);
        check("midrst tmo_cnt", tmo_cnt, 0);
        check("midrst rdata", rdata, 0);
        check("midrst err", err, 0);
        check("midrst paddr", apb.paddr, 0);
        rst       = 1'b0;
        model_tmo = 0;
        s_pready  = 1'b1;
        saw       = 1'b0;
        repeat (4) begin
            tick;
            if (ready) saw = 1'b1;
        end
        check("midrst no pulse", saw, 0);
        s_pready = 1'b0;
        xfer("post rst", 32'h204, 32'h0, 4'b0000, 0, 1'b0, 32'h0BAD_CAFE, 3, 32'h0BAD_CAFE,
             1'b0, 1'b0, 1'b1);

        // Disabled timeout: dut_z must wait as long as the slave stalls.
        mem_valid = 1'b1;
        mem_addr  = 32'h80;
        mem_wstrb = 4'b0000;
        s_pready  = 1'b0;
        tick;
        saw = 1'b0;
        repeat (30) begin
            tick;
            if (ready_z) saw = 1'b1;
        end
        check("tmo0 no ready", saw, 0);
        check("tmo0 psel", apb_z.psel, 1);
        check("tmo0 penable", apb_z.penable, 1);
        s_pready = 1'b1;
        s_prdata = 32'h5A5A_0001;
        tick;
        check("tmo0 ready", ready_z, 1);
        check("tmo0 rdata", rdata_z, 32'h5A5A_0001);
        check("tmo0 err", err_z, 0);
        check("tmo0 tmo_cnt", tmo_cnt_z, 0);
        mem_valid = 1'b0;
        s_pready  = 1'b0;
        rst       = 1'b1;
        tick;
        rst = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/user_ip_apb_bridge.md
USER_IP_APB_BRIDGE -- requirements
Module: user_ip_apb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max ACCESS cycles before forced error; 0 disables timeout.
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, rdata returned on timeout.
REQ-003 clk_i  input  1  sole clock; all logic rising-edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 mem_valid_i  input  1  request valid; held until mem_ready_o.
REQ-006 mem_addr_i  input  32  byte address.
REQ-007 mem_wdata_i  input  32  write data.
REQ-008 mem_wstrb_i  input  4  byte strobes; 4'b0000 = read.
REQ-009 mem_ready_o  output  1  one-cycle completion pulse.
REQ-010 mem_rdata_o  output  32  read data, valid with mem_ready_o.
REQ-011 mem_err_o  output  1  error flag, valid with mem_ready_o.
REQ-012 tmo_cnt_o  output  8  saturating count of timeouts.
REQ-013 apb  apb4_if.master  -  paddr 32, pprot 3, psel 1, penable 1, pwrite 1, pwdata 32, pstrb 4 out; pready 1, prdata 32, pslverr 1 in.

Function
REQ-014 FSM states IDLE, SETUP, ACCESS, RESP.
REQ-015 IDLE: mem_valid_i=1 -> latch addr, wdata, wstrb; next SETUP.
REQ-016 SETUP: psel=1, penable=0; unconditionally next ACCESS.
REQ-017 ACCESS: psel=1, penable=1; pready=1 -> capture prdata (reads only, else 0) and pslverr; next RESP.
REQ-018 ACCESS with pready=0: timeout counter increments; at TIMEOUT_CYC consecutive pready=0 cycles -> RESP with err=1, rdata=ERR_RDATA, tmo_cnt_o+1 (saturate at 255).
REQ-019 TIMEOUT_CYC=0: ACCESS waits indefinitely.
REQ-020 RESP: mem_ready_o=1 for exactly one cycle; psel=0, penable=0; next IDLE regardless of mem_valid_i.
REQ-021 paddr, pwrite, pwdata, pstrb come from latched request; stable from SETUP through end of ACCESS.
REQ-022 pwrite = |wstrb; pstrb = wstrb on writes, 4'b0000 on reads; pprot = 3'b000.
REQ-023 Latency: pready=1 in first ACCESS cycle -> mem_ready_o 3 cycles after valid sampled in IDLE; min 4 cycles per transfer.
REQ-024 mem_err_o = pslverr OR timeout; mem_rdata_o = 0 on writes.
REQ-025 mem_valid_i and request fields ignored outside IDLE; mem_ready_o never asserts outside RESP.
REQ-026 Timeout counter width $clog2(TIMEOUT_CYC+1); clears on each SETUP entry.

Reset
REQ-027 rst_i=1 -> state IDLE, psel/penable/pwrite 0, paddr/pwdata/pstrb 0, mem_ready_o 0, mem_err_o 0, mem_rdata_o 0, tmo_cnt_o 0, timeout counter 0.
REQ-028 Reset mid-transfer abandons it with no mem_ready_o pulse; psel low in the first cycle after the reset edge.

Structure
REQ-029 Shared package user_ip_apb_pkg holds the state enum and ERR_RDATA default.
REQ-030 Single module; no sub-module.

Verification
REQ-031 Read, slave pready=1, prdata=32'h0000_00FF -> SETUP then ACCESS; mem_ready_o 3 cycles after valid; mem_rdata_o=32'h0000_00FF; mem_err_o=0.
REQ-032 Write addr 32'h04, wdata 32'hA5A5_A5A5, wstrb 4'b0011 -> pwrite=1, pstrb=4'b0011, pwdata stable through ACCESS; mem_rdata_o=0.
REQ-033 Slave holds pready=0 for 3 cycles, then pready=1 with pslverr=1 -> ready 6 cycles after valid; mem_err_o=1.
REQ-034 TIMEOUT_CYC=4, pready stuck 0 -> RESP after 4 ACCESS cycles; mem_rdata_o=32'hDEAD_BEEF; mem_err_o=1; tmo_cnt_o=1; 300 timeouts -> tmo_cnt_o=255.
REQ-035 rst_i asserted during ACCESS -> psel=0 next cycle; no mem_ready_o pulse; a following read completes normally.
